// File: rtl/dma_bus_pkg.sv
// Shared types and default constants for the DMA bus arbiter slice.
package dma_bus_pkg;

    localparam int          DMA_WORD_SIZE       = 16;
    localparam logic [15:0] DMA_BASE_DEFAULT    = 16'h01f4;
    localparam int          DMA_LEN_DEFAULT     = 12;
    localparam int          WDOG_CYCLES_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD       = 3'd1,
        WAIT_SAFE = 3'd2,
        GRANT     = 3'd3,
        RELEASE   = 3'd4,
        DONE      = 3'd5
    } arb_state_t;

endpackage

// File: rtl/dma_grant_watchdog.sv
// Grant watchdog: counts cycles while enabled, cleared on demand, and
// flags expiry in the cycle that completes LIMIT enabled cycles.
module dma_grant_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;

    // Count enabled cycles; hold at the expiry value until cleared.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expire) begin
            count_q <= count_q + 1'b1;
        end
    end

    // count_q holds completed cycles, so LIMIT-1 means this is the last one.
    assign expire = en && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side DMA bus arbiter: turns device data-ready into a DMA command,
// lends the bus once the CPU memory stage is quiet, and reclaims it on
// DMA end (or when the DMA abandons the request).
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | bus owned by CPU, no transfer requested
// CMD       | cmd raised, waiting for DMA bus request
// WAIT_SAFE | BR seen, CPU memory access still in flight; stall CPU
// GRANT     | bus lent to DMA (BG=1), CPU stalled
// RELEASE   | bus taken back, waiting for DMA to drop BR
// DONE      | one-cycle completion interrupt to CPU
module dma_bus_arbiter
    import dma_bus_pkg::*;
#(
    parameter int                   WORD_SIZE   = DMA_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] DMA_BASE    = WORD_SIZE'(DMA_BASE_DEFAULT),
    parameter int                   DMA_LEN     = DMA_LEN_DEFAULT,
    parameter int                   WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 dev_ready,
    input  logic                 BR,
    input  logic                 dma_end,
    input  logic                 cpu_mem_busy,
    output logic                 cmd,
    output logic [WORD_SIZE-1:0] dma_addr,
    output logic [WORD_SIZE-1:0] dma_len,
    output logic                 BG,
    output logic                 cpu_stall,
    output logic                 dma_done_irq,
    output logic                 overrun,
    output logic                 dma_err
);

    arb_state_t state, state_nxt;
    logic       pending_q;
    logic       overrun_q;

    if (WDOG_CYCLES < 1) begin : g_wdog_cfg_check
        $error("WDOG_CYCLES must be at least 1");
    end

`ifdef ARB_WATCHDOG_EN
    logic wdog_expire;
    logic wdog_abort;
    logic abort_q;
    logic err_q;

    dma_grant_watchdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr    (state != GRANT),
        .en     (state == GRANT),
        .expire (wdog_expire)
    );

    // Remember an aborted transfer through RELEASE so DONE is skipped;
    // dma_err is the registered abort event, high for one cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= wdog_abort;
            if (wdog_abort) begin
                abort_q <= 1'b1;
            end else if (state == RELEASE && state_nxt != RELEASE) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign dma_err = err_q;
`else
    assign dma_err = 1'b0;
`endif

    // State register; reset drops every state-decoded output at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
`ifdef ARB_WATCHDOG_EN
        wdog_abort = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (dev_ready || pending_q) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (BR) begin
                    state_nxt = cpu_mem_busy ? WAIT_SAFE : GRANT;
                end
            end
            WAIT_SAFE: begin
                if (!cpu_mem_busy) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A dropped BR without dma_end means the DMA gave up.
                if (dma_end || !BR) begin
                    state_nxt = RELEASE;
                end
`ifdef ARB_WATCHDOG_EN
                else if (wdog_expire) begin
                    state_nxt  = RELEASE;
                    wdog_abort = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!BR) begin
`ifdef ARB_WATCHDOG_EN
                    state_nxt = abort_q ? IDLE : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One-deep request memory for dev_ready arriving while busy; a request
    // that finds the slot full is lost and flagged sticky until reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (dev_ready && pending_q) begin
                overrun_q <= 1'b1;
            end
            if (state == IDLE) begin
                pending_q <= 1'b0;
            end else if (dev_ready) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        cmd          = (state == CMD) || (state == WAIT_SAFE) || (state == GRANT);
        BG           = (state == GRANT);
        cpu_stall    = (state == WAIT_SAFE) || (state == GRANT) || (state == RELEASE);
        dma_done_irq = (state == DONE);
        overrun      = overrun_q;
        dma_addr     = cmd ? DMA_BASE : '0;
        dma_len      = cmd ? WORD_SIZE'(DMA_LEN) : '0;
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios followed by
// random stimulus, all outputs compared each cycle against a flag-based
// reference model of the handshake.
module tb_dma_bus_arbiter;

    localparam int          WS    = 16;
    localparam logic [15:0] BASE  = 16'h01f4;
    localparam int          LEN   = 12;
    localparam int          WDOG  = 64;
`ifdef ARB_WATCHDOG_EN
    localparam bit          WD_ON = 1'b1;
`else
    localparam bit          WD_ON = 1'b0;
`endif

    logic          CLK;
    logic          RESET;
    logic          dev_ready, BR, dma_end, cpu_mem_busy;
    logic          cmd, BG, cpu_stall, dma_done_irq, overrun, dma_err;
    logic [WS-1:0] dma_addr, dma_len;

    int n_checks = 0;
    int n_pass   = 0;

    dma_bus_arbiter #(
        .WORD_SIZE   (WS),
        .DMA_BASE    (BASE),
        .DMA_LEN     (LEN),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .dev_ready    (dev_ready),
        .BR           (BR),
        .dma_end      (dma_end),
        .cpu_mem_busy (cpu_mem_busy),
        .cmd          (cmd),
        .dma_addr     (dma_addr),
        .dma_len      (dma_len),
        .BG           (BG),
        .cpu_stall    (cpu_stall),
        .dma_done_irq (dma_done_irq),
        .overrun      (overrun),
        .dma_err      (dma_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: which phase of the handshake the bus is in.
    bit m_req, m_hold, m_lent, m_back, m_note;
    bit m_pend, m_ovr, m_abort, m_err;
    int m_gcnt;

    task automatic model_reset();
        {m_req, m_hold, m_lent, m_back, m_note} = '0;
        {m_pend, m_ovr, m_abort, m_err} = '0;
        m_gcnt = 0;
    endtask

    task automatic model_step(input bit dev, input bit br, input bit den, input bit busy);
        bit idle;
        bit n_req, n_hold, n_lent, n_back, n_note, n_err, n_abort;
        idle = !(m_req || m_hold || m_lent || m_back || m_note);
        {n_req, n_hold, n_lent, n_back, n_note, n_err} = '0;
        n_abort = m_abort;
        if (!m_lent) m_gcnt = 0;
        if (idle) n_req = dev || m_pend;
        if (m_req) begin
            if (!br)       n_req  = 1'b1;
            else if (busy) n_hold = 1'b1;
            else           n_lent = 1'b1;
        end
        if (m_hold) begin
            if (busy) n_hold = 1'b1;
            else      n_lent = 1'b1;
        end
        if (m_lent) begin
            m_gcnt++;
            if (den || !br) n_back = 1'b1;
            else if (WD_ON && m_gcnt >= WDOG) begin
                n_back = 1'b1; n_abort = 1'b1; n_err = 1'b1;
            end else n_lent = 1'b1;
        end
        if (m_back) begin
            if (br) n_back = 1'b1;
            else begin
                n_note  = !m_abort;
                n_abort = 1'b0;
            end
        end
        if (dev && m_pend) m_ovr = 1'b1;
        if (idle)     m_pend = 1'b0;
        else if (dev) m_pend = 1'b1;
        {m_req, m_hold, m_lent, m_back, m_note, m_err, m_abort} =
            {n_req, n_hold, n_lent, n_back, n_note, n_err, n_abort};
    endtask

    int cyc = 0;

    // Apply inputs at the falling edge, advance the model, check after the rising edge.
    task automatic run_cycle(input bit dev, input bit br, input bit den, input bit busy);
        bit unsafe;
        bit m_cmd;
        unsafe = busy && !m_lent;
        dev_ready = dev; BR = br; dma_end = den; cpu_mem_busy = busy;
        model_step(dev, br, den, busy);
        @(posedge CLK);
        #1;
        cyc++;
        m_cmd = m_req || m_hold || m_lent;
        chk_eq($sformatf("outs@%0d", cyc),
               {cmd, BG, cpu_stall, dma_done_irq, overrun, dma_err},
               {m_cmd, m_lent, m_hold || m_lent || m_back, m_note, m_ovr, m_err});
        chk_eq($sformatf("addr@%0d", cyc), dma_addr, m_cmd ? BASE : 16'h0);
        chk_eq($sformatf("len@%0d", cyc), dma_len, m_cmd ? 16'(LEN) : 16'h0);
        if (unsafe) chk_eq($sformatf("bg_safe@%0d", cyc), BG, 1'b0);
        @(negedge CLK);
    endtask

    int bg_cnt, err_cnt, done_cnt;

    initial begin
        RESET = 1'b1;
        dev_ready = 1'b0; BR = 1'b0; dma_end = 1'b0; cpu_mem_busy = 1'b0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        chk_eq("reset_outs",
               {cmd, BG, cpu_stall, dma_done_irq, overrun, dma_err, dma_addr, dma_len}, '0);
        RESET = 1'b0;

        // Basic transfer with BR looped back from cmd.
        done_cnt = 0;
        run_cycle(1, 0, 0, 0);
        chk_eq("basic_cmd", cmd, 1'b1);
        chk_eq("basic_addr", dma_addr, 16'h01f4);
        chk_eq("basic_len", dma_len, 16'd12);
        run_cycle(0, 1, 0, 0);
        chk_eq("basic_bg", BG, 1'b1);
        for (int i = 0; i < 10; i++) run_cycle(0, 1, 0, 0);
        run_cycle(0, 1, 1, 0);
        chk_eq("basic_release", {BG, cmd, cpu_stall}, 3'b001);
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 0, 0);
            done_cnt += int'(dma_done_irq);
        end
        chk_eq("basic_done_once", done_cnt, 1);

        // CPU memory busy for 3 cycles after BR.
        run_cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 1, 0, 1);
            chk_eq("busy_wait", {BG, cpu_stall, cmd}, 3'b011);
        end
        run_cycle(0, 1, 0, 0);
        chk_eq("busy_grant", BG, 1'b1);
        run_cycle(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);

        // Back-to-back with overrun.
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 1, 0, 0);
        run_cycle(1, 1, 0, 0);
        run_cycle(0, 1, 0, 0);
        run_cycle(1, 1, 0, 0);
        chk_eq("ovr_set", overrun, 1'b1);
        run_cycle(0, 1, 1, 0);
        run_cycle(0, 0, 0, 0);
        chk_eq("ovr_done_a", dma_done_irq, 1'b1);
        run_cycle(0, 0, 0, 0);
        chk_eq("ovr_idle", cmd, 1'b0);
        run_cycle(0, 0, 0, 0);
        chk_eq("ovr_b_cmd", cmd, 1'b1);
        run_cycle(0, 1, 0, 0);
        run_cycle(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0);
        chk_eq("ovr_sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a grant.
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 1, 0, 0);
        #2;
        RESET = 1'b1;
        #1;
        chk_eq("async_rst", {BG, cmd, cpu_stall, overrun}, 4'b0000);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle(0, 1, 0, 0);
            done_cnt += int'(dma_done_irq);
        end
        chk_eq("rst_no_done", done_cnt, 0);

        // Grant held with no dma_end.
        run_cycle(1, 0, 0, 0);
        run_cycle(0, 1, 0, 0);
        bg_cnt = 0; err_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            bg_cnt += int'(BG);
            run_cycle(0, 1, 0, 0);
            err_cnt  += int'(dma_err);
            done_cnt += int'(dma_done_irq);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 0, 0);
            err_cnt  += int'(dma_err);
            done_cnt += int'(dma_done_irq);
        end
        chk_eq("wd_bg_cycles", bg_cnt, WD_ON ? WDOG : 200);
        chk_eq("wd_err_cnt", err_cnt, WD_ON ? 1 : 0);
        chk_eq("wd_done_cnt", done_cnt, WD_ON ? 0 : 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom % 8) == 0, ($urandom % 10) < 6,
                      ($urandom % 10) == 0, ($urandom % 10) < 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
